// File: rtl/jtbubl_share_arb_pkg.sv
// rtl/jtbubl_share_arb_pkg.sv - shared types and constants for the work-RAM arbiter
package jtbubl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam int         NREQ     = 3;
    localparam logic [1:0] REQ_MAIN = 2'd0;
    localparam logic [1:0] REQ_SUB  = 2'd1;
    localparam logic [1:0] REQ_MCU  = 2'd2;

    // Modulo-3 increment of a requester index
    function automatic logic [1:0] rr_next(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/jtbubl_share_arb_if.sv
// rtl/jtbubl_share_arb_if.sv - requester and RAM-side signal bundle for the arbiter
interface jtbubl_share_arb_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          main_cs,   sub_cs,   mcu_cs;
    logic          main_wr,   sub_wr,   mcu_wr;
    logic [AW-1:0] main_addr, sub_addr, mcu_addr;
    logic [DW-1:0] main_dout, sub_dout, mcu_dout;
    logic [DW-1:0] main_q,    sub_q,    mcu_q;
    logic          main_wait_n, sub_wait_n, mcu_wait_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    modport master (
        output main_cs, sub_cs, mcu_cs,
        output main_wr, sub_wr, mcu_wr,
        output main_addr, sub_addr, mcu_addr,
        output main_dout, sub_dout, mcu_dout,
        output ram_q,
        input  main_q, sub_q, mcu_q,
        input  main_wait_n, sub_wait_n, mcu_wait_n,
        input  ram_addr, ram_din, ram_we
    );

    modport slave (
        input  main_cs, sub_cs, mcu_cs,
        input  main_wr, sub_wr, mcu_wr,
        input  main_addr, sub_addr, mcu_addr,
        input  main_dout, sub_dout, mcu_dout,
        input  ram_q,
        output main_q, sub_q, mcu_q,
        output main_wait_n, sub_wait_n, mcu_wait_n,
        output ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/jtbubl_share_arb_rr3.sv
// rtl/jtbubl_share_arb_rr3.sv - combinational 3-way round-robin picker
module jtbubl_rr3
    import jtbubl_pkg::*;
(
    input  logic [NREQ-1:0] pend,
    input  logic [1:0]      ptr,
    output logic [1:0]      gnt,
    output logic            any
);
    logic [1:0] c0, c1, c2;
    logic [3:0] p4;

    assign c0  = ptr;
    assign c1  = rr_next(c0);
    assign c2  = rr_next(c1);
    assign p4  = {1'b0, pend};
    assign any = |pend;

    // Later assignments win, so the candidate nearest ptr has priority
    always_comb begin
        gnt = c0;
        if (p4[c2]) gnt = c2;
        if (p4[c1]) gnt = c1;
        if (p4[c0]) gnt = c0;
    end
endmodule

// File: rtl/jtbubl_share_arb.sv
// rtl/jtbubl_share_arb.sv - time-shares one single-port work RAM among main, sub and MCU
module jtbubl_share_arb
    import jtbubl_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic              clk24,
    input  logic              rst,
    jtbubl_share_arb_if.slave bus
);
    logic [NREQ-1:0] cs, wr, pend, done;
    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   dout_a [NREQ];
    logic [DW-1:0]   q_r    [NREQ];

    state_t          state;
    logic [1:0]      ptr, gsel, gnt;
    logic            any;
    logic [AW-1:0]   ram_addr_r;
    logic [DW-1:0]   ram_din_r;
    logic            ram_we_r;

    assign cs[REQ_MAIN]     = bus.main_cs;
    assign cs[REQ_SUB]      = bus.sub_cs;
    assign cs[REQ_MCU]      = bus.mcu_cs;
    assign wr[REQ_MAIN]     = bus.main_wr;
    assign wr[REQ_SUB]      = bus.sub_wr;
    assign wr[REQ_MCU]      = bus.mcu_wr;
    assign addr_a[REQ_MAIN] = bus.main_addr;
    assign addr_a[REQ_SUB]  = bus.sub_addr;
    assign addr_a[REQ_MCU]  = bus.mcu_addr;
    assign dout_a[REQ_MAIN] = bus.main_dout;
    assign dout_a[REQ_SUB]  = bus.sub_dout;
    assign dout_a[REQ_MCU]  = bus.mcu_dout;

    // Stall is combinational so the CPU is held in the very cycle cs rises
    assign pend = cs & ~done;

    assign bus.main_wait_n = ~pend[REQ_MAIN];
    assign bus.sub_wait_n  = ~pend[REQ_SUB];
    assign bus.mcu_wait_n  = ~pend[REQ_MCU];
    assign bus.main_q      = q_r[REQ_MAIN];
    assign bus.sub_q       = q_r[REQ_SUB];
    assign bus.mcu_q       = q_r[REQ_MCU];
    assign bus.ram_addr    = ram_addr_r;
    assign bus.ram_din     = ram_din_r;
    assign bus.ram_we      = ram_we_r;

    jtbubl_rr3 u_rr3 (
        .pend (pend),
        .ptr  (ptr),
        .gnt  (gnt),
        .any  (any)
    );

    always_ff @(posedge clk24) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= REQ_MAIN;
            gsel       <= REQ_MAIN;
            done       <= '0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= '0;
            ram_din_r  <= '0;
            for (int i = 0; i < NREQ; i++) q_r[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!cs[i]) done[i] <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (any) begin
                        gsel       <= gnt;
                        ram_addr_r <= addr_a[gnt];
                        ram_din_r  <= dout_a[gnt];
                        ram_we_r   <= wr[gnt];
                        state      <= ACC;
                    end else begin
                        ram_we_r   <= 1'b0;
                    end
                end
                ACC: begin
                    // ram_we_r still holds the granted direction here
                    if (ram_we_r) begin
                        if (cs[gsel]) done[gsel] <= 1'b1;
                        ram_we_r <= 1'b0;
                        ptr      <= rr_next(gsel);
                        state    <= IDLE;
                    end else begin
                        state    <= RD;
                    end
                end
                RD: begin
                    q_r[gsel] <= bus.ram_q;
                    if (cs[gsel]) done[gsel] <= 1'b1;
                    ptr       <= rr_next(gsel);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtbubl_share_arb.sv
// tb/tb_jtbubl_share_arb.sv - directed self-checking bench for jtbubl_share_arb
module tb_jtbubl_share_arb;
    import jtbubl_pkg::*;

    logic clk24 = 1'b0;
    logic rst   = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  mem [0:8191];
    logic        pre_we   = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    jtbubl_share_arb_if #(.AW(13), .DW(8)) bus ();

    jtbubl_share_arb #(.AW(13), .DW(8)) dut (
        .clk24 (clk24),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk24 = ~clk24;

    always @(posedge clk24) begin
        if (pre_we)      mem[pre_addr]     <= pre_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_q <= mem[bus.ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic step;
        @(posedge clk24);
        #1;
    endtask

    task automatic smp;
        @(negedge clk24);
    endtask

    task automatic set_req(input int i, input logic c, input logic w,
                           input logic [12:0] a, input logic [7:0] d);
        case (i)
            0: begin bus.main_cs = c; bus.main_wr = w; bus.main_addr = a; bus.main_dout = d; end
            1: begin bus.sub_cs  = c; bus.sub_wr  = w; bus.sub_addr  = a; bus.sub_dout  = d; end
            default: begin bus.mcu_cs = c; bus.mcu_wr = w; bus.mcu_addr = a; bus.mcu_dout = d; end
        endcase
    endtask

    function automatic logic wait_of(input int i);
        case (i)
            0: return bus.main_wait_n;
            1: return bus.sub_wait_n;
            default: return bus.mcu_wait_n;
        endcase
    endfunction

    function automatic logic [7:0] q_of(input int i);
        case (i)
            0: return bus.main_q;
            1: return bus.sub_q;
            default: return bus.mcu_q;
        endcase
    endfunction

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step;
        pre_we = 1'b0;
    endtask

    task automatic do_reset;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    // Raise cs, wait up to 16 cycles for wait_n, then release cs
    task automatic access(input int i, input logic w, input logic [12:0] a,
                          input logic [7:0] d, output int lat, output logic [7:0] q);
        lat = -1;
        set_req(i, 1'b1, w, a, d);
        for (int c = 0; c < 16; c++) begin
            smp;
            if (wait_of(i)) begin lat = c; break; end
            step;
        end
        q = q_of(i);
        step;
        set_req(i, 1'b0, w, a, d);
        step;
    endtask

    task automatic test_reset;
        do_reset;
        smp;
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
        checks++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 13'h0 || bus.ram_din !== 8'h0) begin
            errors++; $display("FAIL reset_ram: we %b addr %h din %h want 0 0 0", bus.ram_we, bus.ram_addr, bus.ram_din); end
        checks++; if ({bus.main_q, bus.sub_q, bus.mcu_q} !== 24'h0) begin
            errors++; $display("FAIL reset_q: got %h %h %h want 00 00 00", bus.main_q, bus.sub_q, bus.mcu_q); end
        checks++; if ({bus.main_wait_n, bus.sub_wait_n, bus.mcu_wait_n} !== 3'b111) begin
            errors++; $display("FAIL reset_wait_n: got %b want 111", {bus.main_wait_n, bus.sub_wait_n, bus.mcu_wait_n}); end
    endtask

    task automatic test_main_read;
        do_reset;
        preload(13'h0123, 8'h5A);
        set_req(0, 1'b1, 1'b0, 13'h0123, 8'h00);
        smp;
        checks++; if (bus.main_wait_n !== 1'b0) begin errors++; $display("FAIL rd_wait_t0: got %b want 0", bus.main_wait_n); end
        step; smp;
        checks++; if (bus.ram_addr !== 13'h0123) begin errors++; $display("FAIL rd_addr_t1: got %h want 0123", bus.ram_addr); end
        step; smp;
        checks++; if (bus.main_wait_n !== 1'b0) begin errors++; $display("FAIL rd_wait_t2: got %b want 0", bus.main_wait_n); end
        step; smp;
        checks++; if (bus.main_q !== 8'h5A || bus.main_wait_n !== 1'b1) begin
            errors++; $display("FAIL rd_t3: q %h wait_n %b want 5a 1", bus.main_q, bus.main_wait_n); end
        step;
        set_req(0, 1'b0, 1'b0, '0, '0);
        step;
    endtask

    task automatic test_write_read;
        int we_cnt, lat, lat2;
        logic [7:0] q;
        do_reset;
        we_cnt = 0; lat = -1;
        set_req(1, 1'b1, 1'b1, 13'h1FFF, 8'hC3);
        for (int c = 0; c < 8; c++) begin
            smp;
            if (bus.ram_we) we_cnt++;
            if (bus.sub_wait_n && lat < 0) lat = c;
            step;
        end
        set_req(1, 1'b0, 1'b0, '0, '0);
        step;
        checks++; if (we_cnt != 1) begin errors++; $display("FAIL wr_we_pulses: got %0d want 1", we_cnt); end
        checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++; if (mem[13'h1FFF] !== 8'hC3) begin errors++; $display("FAIL wr_mem: got %h want c3", mem[13'h1FFF]); end
        access(0, 1'b0, 13'h1FFF, 8'h00, lat2, q);
        checks++; if (q !== 8'hC3 || lat2 != 3) begin errors++; $display("FAIL wr_readback: q %h lat %0d want c3 3", q, lat2); end
    endtask

    task automatic test_simultaneous;
        int first [3];
        do_reset;
        preload(13'h0010, 8'h11);
        preload(13'h0020, 8'h22);
        preload(13'h0030, 8'h33);
        for (int i = 0; i < 3; i++) first[i] = -1;
        set_req(0, 1'b1, 1'b0, 13'h0010, 8'h00);
        set_req(1, 1'b1, 1'b0, 13'h0020, 8'h00);
        set_req(2, 1'b1, 1'b0, 13'h0030, 8'h00);
        for (int c = 0; c < 12; c++) begin
            smp;
            for (int i = 0; i < 3; i++) if (wait_of(i) && first[i] < 0) first[i] = c;
            if (c == 1) begin checks++; if (bus.ram_addr !== 13'h0010) begin errors++; $display("FAIL sim_gnt1: got %h want 0010", bus.ram_addr); end end
            if (c == 4) begin checks++; if (bus.ram_addr !== 13'h0020) begin errors++; $display("FAIL sim_gnt2: got %h want 0020", bus.ram_addr); end end
            if (c == 7) begin checks++; if (bus.ram_addr !== 13'h0030) begin errors++; $display("FAIL sim_gnt3: got %h want 0030", bus.ram_addr); end end
            step;
        end
        checks++; if (first[0] != 3 || first[1] != 6 || first[2] != 9) begin
            errors++; $display("FAIL sim_wait_n: got %0d %0d %0d want 3 6 9", first[0], first[1], first[2]); end
        checks++; if ({bus.main_q, bus.sub_q, bus.mcu_q} !== 24'h112233) begin
            errors++; $display("FAIL sim_q: got %h %h %h want 11 22 33", bus.main_q, bus.sub_q, bus.mcu_q); end
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        step;
    endtask

    task automatic test_ptr1;
        int lat;
        int first [3];
        logic [7:0] q;
        do_reset;
        access(0, 1'b0, 13'h0001, 8'h00, lat, q);
        checks++; if (dut.ptr !== 2'd1) begin errors++; $display("FAIL ptr_after_main: got %0d want 1", dut.ptr); end
        preload(13'h0100, 8'hAA);
        preload(13'h0200, 8'hBB);
        for (int i = 0; i < 3; i++) first[i] = -1;
        set_req(0, 1'b1, 1'b0, 13'h0100, 8'h00);
        set_req(2, 1'b1, 1'b0, 13'h0200, 8'h00);
        for (int c = 0; c < 9; c++) begin
            smp;
            for (int i = 0; i < 3; i++) if (wait_of(i) && first[i] < 0) first[i] = c;
            if (c == 1) begin checks++; if (bus.ram_addr !== 13'h0200) begin errors++; $display("FAIL ptr1_first_gnt: got %h want 0200", bus.ram_addr); end end
            step;
        end
        checks++; if (first[2] != 3 || first[0] != 6) begin
            errors++; $display("FAIL ptr1_order: mcu %0d main %0d want 3 6", first[2], first[0]); end
        checks++; if (bus.main_q !== 8'hAA || bus.mcu_q !== 8'hBB) begin
            errors++; $display("FAIL ptr1_q: main %h mcu %h want aa bb", bus.main_q, bus.mcu_q); end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b0, 1'b0, '0, '0);
        step;
    endtask

    task automatic test_cs_drop;
        int lat;
        logic [7:0] q;
        do_reset;
        preload(13'h0040, 8'h00);
        set_req(1, 1'b1, 1'b1, 13'h0040, 8'h77);
        smp;
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL drop_we_t0: got %b want 0", bus.ram_we); end
        step;
        set_req(1, 1'b0, 1'b1, 13'h0040, 8'h77);
        smp;
        checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL drop_we_t1: got %b want 1", bus.ram_we); end
        step; smp;
        checks++; if (dut.done[1] !== 1'b0) begin errors++; $display("FAIL drop_done: got %b want 0", dut.done[1]); end
        checks++; if (mem[13'h0040] !== 8'h77) begin errors++; $display("FAIL drop_mem: got %h want 77", mem[13'h0040]); end
        checks++; if (bus.ram_we !== 1'b0 || dut.state !== IDLE) begin
            errors++; $display("FAIL drop_idle: we %b state %0d want 0 %0d", bus.ram_we, dut.state, IDLE); end
        step;
        access(1, 1'b0, 13'h0040, 8'h00, lat, q);
        checks++; if (lat != 3 || q !== 8'h77) begin errors++; $display("FAIL drop_rereq: lat %0d q %h want 3 77", lat, q); end
    endtask

    task automatic test_reset_in_rd;
        int lat;
        do_reset;
        preload(13'h0200, 8'hA5);
        set_req(0, 1'b1, 1'b0, 13'h0200, 8'h00);
        step;
        step;
        rst = 1'b1;
        smp;
        checks++; if (dut.state !== RD) begin errors++; $display("FAIL rrd_in_rd: got %0d want %0d", dut.state, RD); end
        step;
        rst = 1'b0;
        smp;
        checks++; if (dut.state !== IDLE || bus.main_q !== 8'h00 || bus.main_wait_n !== 1'b0) begin
            errors++; $display("FAIL rrd_after: state %0d q %h wait_n %b want %0d 00 0", dut.state, bus.main_q, bus.main_wait_n, IDLE); end
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) smp;
            if (bus.main_wait_n) begin lat = c; break; end
            step;
        end
        checks++; if (lat != 3 || bus.main_q !== 8'hA5) begin
            errors++; $display("FAIL rrd_reserve: lat %0d q %h want 3 a5", lat, bus.main_q); end
        step;
        set_req(0, 1'b0, 1'b0, '0, '0);
        step;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, '0, '0);
        test_reset;
        test_main_read;
        test_write_read;
        test_simultaneous;
        test_ptr1;
        test_cs_drop;
        test_reset_in_rd;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
